// File: rtl/i2c_master.sv
// Single-byte I2C master: after reset it runs one read or write transaction
// to SLAVE_ADDR, then parks in DONE until the next reset.
// All bus outputs are registered. Each bit slot is one low cycle followed by
// one high cycle, and SDA is sampled on the edge that ends the high cycle.
module i2c_master #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [2:0] state,
    output logic       sclk,
    input  logic       sda_in,
    output logic       sda_out
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDRESSING = 3'd1,
        WAITING    = 3'd2,
        READING    = 3'd3,
        WRITING    = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t     state_q;
    logic [4:0] cnt;      // cycle index within the current state
    logic       rw_q;
    logic [7:0] data_q;
    logic [7:0] tx;       // outgoing bits, MSB is next to drive
    logic [7:0] rx;       // incoming bits, shifted in MSB first

    assign state = state_q;

    // Transaction sequencer. Every output is set for the *next* cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt      <= '0;
            sclk     <= 1'b1;
            sda_out  <= 1'b1;
            data_out <= '0;
            rw_q     <= 1'b0;
            data_q   <= '0;
            tx       <= '0;
            rx       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Latch the request and issue START (SDA falls, SCL high)
                    rw_q    <= rw;
                    data_q  <= data_in;
                    tx      <= {SLAVE_ADDR, rw};
                    sclk    <= 1'b1;
                    sda_out <= 1'b0;
                    cnt     <= '0;
                    state_q <= ADDRESSING;
                end
                ADDRESSING: begin
                    // cnt 0 is START, odd cnt are low cycles, even (>0) high
                    if (cnt == 5'd16) begin
                        state_q <= WAITING;
                        cnt     <= '0;
                        sclk    <= 1'b0;
                        sda_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (!cnt[0]) begin
                            sclk    <= 1'b0;
                            sda_out <= tx[7];
                            tx      <= {tx[6:0], 1'b0};
                        end else begin
                            sclk <= 1'b1;
                        end
                    end
                end
                WAITING: begin
                    // cnt 0/1: ACK slot; cnt 2/3 only exist on the NACK STOP path
                    case (cnt)
                        5'd0: begin
                            sclk <= 1'b1;
                            cnt  <= 5'd1;
                        end
                        5'd1: begin
                            sclk <= 1'b0;
                            if (!sda_in) begin
                                cnt     <= '0;
                                state_q <= rw_q ? READING : WRITING;
                                if (rw_q) begin
                                    sda_out <= 1'b1;
                                end else begin
                                    sda_out <= data_q[7];
                                    tx      <= {data_q[6:0], 1'b0};
                                end
                            end else begin
                                cnt     <= 5'd2;
                                sda_out <= 1'b0;
                            end
                        end
                        5'd2: begin
                            sclk <= 1'b1;
                            cnt  <= 5'd3;
                        end
                        default: begin
                            state_q <= DONE;
                            cnt     <= '0;
                            sclk    <= 1'b1;
                            sda_out <= 1'b1;
                        end
                    endcase
                end
                READING, WRITING: begin
                    // cnt 0-15 data slots, 16-17 ack slot, 18-19 STOP
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd19) begin
                        state_q <= DONE;
                        cnt     <= '0;
                        sclk    <= 1'b1;
                        sda_out <= 1'b1;
                    end else if (cnt == 5'd18) begin
                        sclk <= 1'b1;
                    end else if (cnt == 5'd17) begin
                        sclk    <= 1'b0;
                        sda_out <= 1'b0;
                    end else if (!cnt[0]) begin
                        sclk <= 1'b1;
                    end else begin
                        // End of a data high cycle: sample (read) and set up next low cycle
                        sclk <= 1'b0;
                        if (state_q == READING) begin
                            rx      <= {rx[6:0], sda_in};
                            sda_out <= 1'b1;
                            if (cnt == 5'd15)
                                data_out <= {rx[6:0], sda_in};
                        end else begin
                            sda_out <= (cnt == 5'd15) ? 1'b1 : tx[7];
                            tx      <= {tx[6:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    // Park with the bus released
                    sclk    <= 1'b1;
                    sda_out <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    cnt     <= '0;
                    sclk    <= 1'b1;
                    sda_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master. Each scenario pushes the expected
// per-cycle bus/state picture into a queue. A monitor pops one entry per
// cycle (sampled at the falling clk edge) and compares it. A behavioural
// slave drives sda_in by cycle number.
module tb_i2c_master;

    typedef struct packed {
        logic [2:0] st;
        logic       scl;
        logic       sda;
        logic [7:0] dout;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [2:0] state;
    logic       sclk;
    logic       sda_in = 1'b1;
    logic       sda_out;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;              // number of rising edges since reset release
    obs_t q[$];

    // scenario description
    bit       sc_rw, sc_nack;
    bit [7:0] sc_abyte, sc_wdata, sc_rbyte;

    i2c_master #(.SLAVE_ADDR(7'h50)) dut (
        .clk(clk), .rst(rst_n), .rw(rw), .data_in(data_in), .data_out(data_out),
        .state(state), .sclk(sclk), .sda_in(sda_in), .sda_out(sda_out)
    );

    always #5 clk = ~clk;

    // edge counter: after edge k this holds k, so cycle k is in progress when it reads k-1
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    // Expected picture of cycle k, built from the cycle table
    function automatic obs_t expv(int k);
        obs_t e;
        e = '{st: 3'd0, scl: 1'b1, sda: 1'b1, dout: 8'h00};
        if (k == 1) begin
        end else if (k == 2) begin
            e.st = 3'd1; e.sda = 1'b0;
        end else if (k <= 18) begin
            e.st = 3'd1; e.scl = (k % 2 == 0); e.sda = sc_abyte[7 - (k - 3) / 2];
        end else if (k <= 20) begin
            e.st = 3'd2; e.scl = (k == 20);
        end else if (sc_nack) begin
            if (k == 21)      begin e.st = 3'd2; e.scl = 1'b0; e.sda = 1'b0; end
            else if (k == 22) begin e.st = 3'd2; e.sda = 1'b0; end
            else              e.st = 3'd5;
        end else if (k <= 36) begin
            e.st  = sc_rw ? 3'd3 : 3'd4;
            e.scl = (k % 2 == 0);
            e.sda = sc_rw ? 1'b1 : sc_wdata[7 - (k - 21) / 2];
        end else if (k <= 40) begin
            e.st  = sc_rw ? 3'd3 : 3'd4;
            e.scl = (k == 38 || k == 40);
            e.sda = (k <= 38);
        end else begin
            e.st = 3'd5;
        end
        if (sc_rw && !sc_nack && k >= 37) e.dout = sc_rbyte;
        return e;
    endfunction

    // Behavioural slave: what it puts on SDA during cycle k
    function automatic bit slave_bit(int k);
        if (k == 20) return sc_nack;
        if (sc_rw && !sc_nack && k >= 21 && k <= 36) return sc_rbyte[7 - (k - 21) / 2];
        if (!sc_rw && !sc_nack && k == 38) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) sda_in = slave_bit(cyc + 1);

    // Monitor: one expected entry per cycle while out of reset
    always @(negedge clk) begin
        obs_t e, a;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            a = {state, sclk, sda_out, data_out};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle%0d: got st=%0d scl=%b sda=%b dout=%h, want st=%0d scl=%b sda=%b dout=%h",
                         cyc + 1, a.st, a.scl, a.sda, a.dout, e.st, e.scl, e.sda, e.dout);
            end
        end
    end

    task automatic check_rst(string nm);
        #1;
        n_tests++;
        if ({state, sclk, sda_out, data_out} !== {3'd0, 1'b1, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL %s: got st=%0d scl=%b sda=%b dout=%h, want st=0 scl=1 sda=1 dout=00",
                     nm, state, sclk, sda_out, data_out);
        end
    endtask

    // Hold reset, load the scenario and its expectations, release just after an edge
    task automatic start(bit rw_v, bit [7:0] wd, bit [7:0] rb, bit nack, bit [7:0] ab, int n);
        rst_n = 1'b0;
        q.delete();
        sc_rw = rw_v; sc_wdata = wd; sc_rbyte = rb; sc_nack = nack; sc_abyte = ab;
        rw = rw_v; data_in = wd;
        repeat (2) @(posedge clk);
        check_rst("in_reset");
        for (int k = 1; k <= n; k++) q.push_back(expv(k));
        @(posedge clk);
        #1 rst_n = 1'b1;
        // inputs change after IDLE has latched them; the DUT must ignore this
        @(posedge clk);
        #1 rw = ~rw_v; data_in = ~wd;
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() > 0 && b < 400) begin
            @(posedge clk);
            b++;
        end
        if (q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d entries left, want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time %0t, want finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Read, ACK, slave returns 0xF6; address byte 0xA1
        start(1'b1, 8'h00, 8'hF6, 1'b0, 8'hA1, 45);
        drain();
        // Async reset while parked in DONE clears data_out at once
        @(negedge clk); #2 rst_n = 1'b0;
        check_rst("rst_in_done");

        // Write 0x3C, address byte 0xA0, then hold DONE for 100 cycles
        start(1'b0, 8'h3C, 8'h00, 1'b0, 8'hA0, 141);
        drain();

        // Address NACK: STOP then DONE at cycle 23
        start(1'b1, 8'h00, 8'h00, 1'b1, 8'hA1, 50);
        drain();

        // Reset mid-READING at cycle 28, then the full transaction again
        start(1'b1, 8'h00, 8'h5A, 1'b0, 8'hA1, 40);
        begin
            int b = 0;
            while (cyc < 27 && b < 100) begin
                @(posedge clk);
                b++;
            end
        end
        @(negedge clk); #2 rst_n = 1'b0;
        check_rst("rst_mid_read");
        start(1'b1, 8'h00, 8'h5A, 1'b0, 8'hA1, 45);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
